// File: rtl/dft_result_reader_if.sv
// Output stream from the DFT result reader to the magnitude/peak stage.
// A bin is transferred on any clock edge where valid_o and ready_i are both high.
interface dft_result_reader_if #(
  parameter int NUM_BINS  = 24,
  parameter int OUT_WIDTH = 16,
  parameter int BIN_WIDTH = $clog2(NUM_BINS)
);
  logic                        valid_o;
  logic                        ready_i;
  logic [BIN_WIDTH-1:0]        bin_o;
  logic signed [OUT_WIDTH-1:0] real_o;
  logic signed [OUT_WIDTH-1:0] imag_o;
  logic                        sat_o;
  logic                        last_o;

  modport master (
    output valid_o, bin_o, real_o, imag_o, sat_o, last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, bin_o, real_o, imag_o, sat_o, last_o,
    output ready_i
  );
endinterface

// File: rtl/dft_result_reader.sv
// Snapshots one frame of DFT accumulator bins and streams them out one bin per
// handshake, rounded, scaled down by SHIFT and saturated to OUT_WIDTH.
module dft_result_reader #(
  parameter int ACCUM_WIDTH = 48,
  parameter int NUM_BINS    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 24,
  parameter int BIN_WIDTH   = $clog2(NUM_BINS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [ACCUM_WIDTH-1:0] A_real_i [NUM_BINS],
  input  logic signed [ACCUM_WIDTH-1:0] A_imag_i [NUM_BINS],
  input  logic                          valid_i,
  input  logic                          clear_i,
  dft_result_reader_if.master           stream,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          overrun_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [BIN_WIDTH-1:0] ONE      = {{(BIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BIN_WIDTH-1:0] ZERO_IDX = {BIN_WIDTH{1'b0}};
  localparam logic [BIN_WIDTH-1:0] PEN_IDX  = BIN_WIDTH'(NUM_BINS - 2);

  // Rounding constant and clamp limits, all ACCUM_WIDTH+1 bits so the add cannot overflow.
  localparam logic signed [ACCUM_WIDTH:0] RND  = {{ACCUM_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACCUM_WIDTH:0] MAXV = {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH:0] MINV = {{(ACCUM_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Returns {saturated, scaled value}.
  function automatic logic [OUT_WIDTH:0] scale(input logic signed [ACCUM_WIDTH-1:0] x);
    logic signed [ACCUM_WIDTH:0] y;
    y = ($signed({x[ACCUM_WIDTH-1], x}) + RND) >>> SHIFT;
    if (y > MAXV) begin
      scale = {1'b1, MAXV[OUT_WIDTH-1:0]};
    end else if (y < MINV) begin
      scale = {1'b1, MINV[OUT_WIDTH-1:0]};
    end else begin
      scale = {1'b0, y[OUT_WIDTH-1:0]};
    end
  endfunction

  state_t                        state_r;
  logic [BIN_WIDTH-1:0]          idx_r;
  logic                          valid_r;
  logic                          last_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          ovr_r;
  logic signed [ACCUM_WIDTH-1:0] snap_real_r [NUM_BINS];
  logic signed [ACCUM_WIDTH-1:0] snap_imag_r [NUM_BINS];

  logic                          xfer_s;
  logic                          last_xfer_s;
  logic                          ovr_evt_s;
  logic [OUT_WIDTH:0]            real_sc_s;
  logic [OUT_WIDTH:0]            imag_sc_s;

  assign xfer_s      = valid_r & stream.ready_i;
  assign last_xfer_s = xfer_s & last_r;
  // A frame arriving while draining is lost unless the last bin leaves at the same edge.
  assign ovr_evt_s   = (state_r == DRAIN) & valid_i & ~last_xfer_s;

  // Scale the currently indexed snapshot entry.
  always_comb begin
    real_sc_s = scale(snap_real_r[idx_r]);
    imag_sc_s = scale(snap_imag_r[idx_r]);
  end

  // Frame capture, drain sequencing and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      idx_r   <= ZERO_IDX;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovr_r   <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        snap_real_r[i] <= {ACCUM_WIDTH{1'b0}};
        snap_imag_r[i] <= {ACCUM_WIDTH{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      if (ovr_evt_s) begin
        ovr_r <= 1'b1;
      end else if (clear_i) begin
        ovr_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            snap_real_r <= A_real_i;
            snap_imag_r <= A_imag_i;
            idx_r       <= ZERO_IDX;
            valid_r     <= 1'b1;
            busy_r      <= 1'b1;
            last_r      <= 1'b0;
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer_s) begin
            if (last_r) begin
              done_r <= 1'b1;
              idx_r  <= ZERO_IDX;
              last_r <= 1'b0;
              if (valid_i) begin
                snap_real_r <= A_real_i;
                snap_imag_r <= A_imag_i;
              end else begin
                valid_r <= 1'b0;
                busy_r  <= 1'b0;
                state_r <= IDLE;
              end
            end else begin
              idx_r  <= idx_r + ONE;
              last_r <= (idx_r == PEN_IDX);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= ZERO_IDX;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign stream.valid_o = valid_r;
  assign stream.bin_o   = idx_r;
  assign stream.last_o  = last_r;
  assign stream.real_o  = real_sc_s[OUT_WIDTH-1:0];
  assign stream.imag_o  = imag_sc_s[OUT_WIDTH-1:0];
  assign stream.sat_o   = real_sc_s[OUT_WIDTH] | imag_sc_s[OUT_WIDTH];
  assign busy_o         = busy_r;
  assign frame_done_o   = done_r;
  assign overrun_o      = ovr_r;

endmodule

// File: doc/dft_result_reader.md
# dft_result_reader

Drains one frame of DFT accumulator results (NUM_BINS complex bins, ACCUM_WIDTH each) presented in parallel by `dft_accumulation` on its one-cycle `valid_o` strobe. It snapshots all bins, then streams them out one bin per handshake with rounding, scaling and saturation to OUT_WIDTH. The output side is a valid/ready stream towards the downstream magnitude/peak stage. The block sits directly after `dft_accumulation` in the analysis chain.

## Interface
- ACCUM_WIDTH, 48, signed accumulator width per real/imag component
- NUM_BINS, 24, bins per frame (≥2)
- OUT_WIDTH, 16, signed output width per component
- SHIFT, 24, right-shift applied before saturation (1 ≤ SHIFT < ACCUM_WIDTH)
- BIN_WIDTH, $clog2(NUM_BINS), width of bin index
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- A_real_i  in  NUM_BINS×ACCUM_WIDTH  accumulator real parts, unpacked array
- A_imag_i  in  NUM_BINS×ACCUM_WIDTH  accumulator imag parts, unpacked array
- valid_i  in  1  frame-ready strobe from accumulator
- clear_i  in  1  clears sticky overrun_o
- ready_i  in  1  downstream accepts current bin
- valid_o  out  1  bin data valid
- bin_o  out  BIN_WIDTH  index of current bin
- real_o  out  OUT_WIDTH  scaled real part
- imag_o  out  OUT_WIDTH  scaled imag part
- sat_o  out  1  real_o or imag_o of current bin saturated
- last_o  out  1  current bin is NUM_BINS-1
- busy_o  out  1  frame draining
- frame_done_o  out  1  one-cycle pulse after last bin transferred
- overrun_o  out  1  sticky: a frame was dropped

## Operation
- States: IDLE, DRAIN.
- IDLE: valid_i=1 at an edge → all A_real_i/A_imag_i copied into the snapshot, idx←0, → DRAIN.
- DRAIN: valid_o=1, busy_o=1. bin_o=idx, last_o=(idx==NUM_BINS-1). real_o/imag_o/sat_o are derived from snapshot[idx].
- Transfer occurs when valid_o & ready_i at an edge.
  - Non-last transfer: idx←idx+1.
  - Last transfer: → IDLE, frame_done_o=1 for the next cycle only.
- Scaling, per component x:
  - Compute y = (x + 2^(SHIFT-1)) >>> SHIFT in ACCUM_WIDTH+1 bits. This is round-half-up with no intermediate overflow.
  - If y > 2^(OUT_WIDTH-1)-1, output 2^(OUT_WIDTH-1)-1. If y < -2^(OUT_WIDTH-1), output -2^(OUT_WIDTH-1). Otherwise output y truncated to OUT_WIDTH.
  - sat_o = saturation occurred on real OR imag.
- Boundary conditions:
  - valid_i during DRAIN with no last transfer at that edge: new frame dropped; snapshot untouched; overrun_o←1.
  - valid_i coinciding with the last transfer: new frame captured; idx←0; state stays DRAIN; no overrun; frame_done_o still pulses.
  - clear_i and an overrun event at the same edge: set wins, so overrun_o=1.
  - ready_i=0: all outputs hold stable while valid_o=1 (standard valid/ready; valid_o never drops without a transfer).
  - Reset mid-frame: immediate return to IDLE. The partial frame is lost and no frame_done_o pulse is generated.

## Timing
- Reset values: state IDLE, idx 0, snapshot 0. Outputs: valid_o 0, bin_o 0, real_o 0, imag_o 0, sat_o 0, last_o 0, busy_o 0, frame_done_o 0, overrun_o 0.
- Latency: valid_i sampled at edge T → valid_o=1 with bin 0 from T+1.
- Throughput: with ready_i held high, bins 0..NUM_BINS-1 appear on consecutive cycles T+1..T+NUM_BINS. frame_done_o is high during T+NUM_BINS+1.
- Back-to-back frames: valid_i at the last-transfer edge gives zero idle cycles between frames.
- All outputs are driven from registers or from the registered snapshot indexed by registered idx through the scaling logic. There is no combinational path from any input to any output.

## Test plan
All scenarios use SHIFT=24, OUT_WIDTH=16, NUM_BINS=24.
- Rounding: bin0 real=2^23, bin1 real=2^23-1, bin2 real=-2^23, bin3 real=-2^23-1, ready_i=1 → real_o values 1, 0, 0, -1; sat_o=0 for all.
- Saturation: bin5 real=2^40, imag=-2^40 → real_o=0x7FFF, imag_o=0x8000, sat_o=1 on bin 5 only.
- Streaming with ready_i=1: bin k loaded with real=k·2^24, imag=-k·2^24 → 24 consecutive beats after valid_i; real_o=k, imag_o=-k; last_o only on bin 23; frame_done_o one cycle after.
- Backpressure: ready_i toggles randomly → every bin delivered exactly once, in order; outputs stable whenever valid_o=1 and ready_i=0.
- Overrun: valid_i pulses at bin 10 → overrun_o=1, original frame still completes unchanged. clear_i then sets overrun_o=0. Repeat with clear_i and valid_i at the same edge → overrun_o=1.
- Back-to-back and reset: valid_i coincides with the last transfer → second frame's bin 0 appears the next cycle, overrun_o stays 0. Assert rst_i at bin 7 → all outputs at reset values immediately; the next valid_i starts a clean frame.
